// File: rtl/wire_cut_judge.sv
// ---------------------------------------------------------------------------
// wire_cut_judge
//
// This block is the referee for the wire-defusal puzzle. It takes the
// debounced wire levels (1 = intact, 0 = cut) and checks each new cut
// against the cut order that was latched when the puzzle was armed. It
// raises a strike pulse for every mistake, counts strikes, tracks progress
// through the cut order, and reports DEFUSED or EXPLODED to the game top
// and the timer.
//
// Parameters
//   NUM_WIRES    number of wires (IDX_W = $clog2(NUM_WIRES))
//   MAX_STRIKES  number of strikes that cause an explosion (>= 1)
//
// Ports
//   clk         system clock
//   rst         synchronous, active-low reset
//   start       arm request, level sampled on every clock
//   wire_lvl    debounced wire levels, 1 = intact
//   cut_order   expected cut sequence, entry k at [k*IDX_W +: IDX_W]
//   cut_len     number of entries that have to be cut
//   game_over   timer has expired
//   state       0 IDLE, 1 ACTIVE, 2 DEFUSED, 3 EXPLODED
//   strike      one-cycle pulse for each strike
//   strike_cnt  strikes so far, saturating at MAX_STRIKES
//   progress    correct cuts and skipped entries so far
//   arm_err     one-cycle pulse when start is seen while a wire is cut
//
// Build option
//   WIRE_RECONNECT_STRIKE_EN
//      When defined, reconnecting a wire (0->1) while ACTIVE is a strike.
//      When undefined, reconnects are ignored. prev still follows them, so
//      a reconnected wire can be cut again and judged.
// ---------------------------------------------------------------------------
module wire_cut_judge #(
   parameter int NUM_WIRES   = 6,
   parameter int MAX_STRIKES = 3,
   localparam int IDX_W      = $clog2(NUM_WIRES),
   localparam int CNT_W      = $clog2(MAX_STRIKES + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [NUM_WIRES-1:0]         wire_lvl,
   input  logic [NUM_WIRES*IDX_W-1:0]   cut_order,
   input  logic [IDX_W:0]               cut_len,
   input  logic                         game_over,
   output logic [1:0]                   state,
   output logic                         strike,
   output logic [CNT_W-1:0]             strike_cnt,
   output logic [IDX_W:0]               progress,
   output logic                         arm_err
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ACTIVE   = 2'd1;
   localparam logic [1:0] ST_DEFUSED  = 2'd2;
   localparam logic [1:0] ST_EXPLODED = 2'd3;

   logic [NUM_WIRES-1:0]       wire_q;
   logic [NUM_WIRES-1:0]       prev;
   logic [NUM_WIRES*IDX_W-1:0] order_q;
   logic [IDX_W:0]             len_q;

   logic [IDX_W-1:0]     exp_idx;
   logic                 exp_in_range;
   logic                 exp_valid;
   logic [NUM_WIRES-1:0] exp_mask;
   logic [NUM_WIRES-1:0] newcut;
   logic                 complete;
   logic                 correct_cut;
   logic                 wrong_cut;
   logic                 skip;
   logic                 reconnect_hit;
   logic                 strike_now;
   logic [IDX_W:0]       len_clamped;

   // Pick the cut-order entry that progress points at. Once progress has
   // run past the last stored entry there is nothing to look up, so the
   // entry is reported as out of range instead of reading past the vector.
   always_comb begin
      exp_idx      = '0;
      exp_in_range = 1'b0;
      for (int k = 0; k < NUM_WIRES; k++) begin
         if (progress == (IDX_W+1)'(k)) begin
            exp_idx      = order_q[k*IDX_W +: IDX_W];
            exp_in_range = 1'b1;
         end
      end
   end

   // Judge the current cycle. A correct cut is exactly one new cut, and it
   // has to be the expected wire. Any other set of new cuts is a single
   // strike. With no new cut, the expected entry is skipped when it names a
   // wire that does not exist or a wire that is already cut. Progress stops
   // moving once it has reached the latched length.
   always_comb begin
      exp_valid   = exp_in_range && ({1'b0, exp_idx} < (IDX_W+1)'(NUM_WIRES));
      exp_mask    = exp_valid ? (NUM_WIRES'(1) << exp_idx) : '0;
      newcut      = prev & ~wire_q;
      complete    = (progress == len_q);
      correct_cut = !complete && exp_valid && (newcut == exp_mask);
      wrong_cut   = (newcut != '0) && !correct_cut;
      skip        = !complete && (newcut == '0) &&
                    (!exp_valid || ((prev & exp_mask) == '0));
`ifdef WIRE_RECONNECT_STRIKE_EN
      reconnect_hit = ((~prev & wire_q) != '0);
`else
      reconnect_hit = 1'b0;
`endif
      strike_now  = wrong_cut || reconnect_hit;
   end

   // A length of zero would count as defused right away, so it is raised
   // to one. Lengths longer than the wire count are cut down to the wire
   // count.
   always_comb begin
      len_clamped = cut_len;
      if (cut_len == '0)
         len_clamped = (IDX_W+1)'(1);
      else if (cut_len > (IDX_W+1)'(NUM_WIRES))
         len_clamped = (IDX_W+1)'(NUM_WIRES);
   end

   // Main game register. wire_q is a one-cycle staging register. Because of
   // it, a wire change sampled at one edge is judged at the following edge.
   // The arm check looks at the live wire levels, so nobody can arm a puzzle
   // that already has a cut wire. The strike pulse and the arm_err pulse
   // default to low and are raised only for the cycle that causes them.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         strike     <= 1'b0;
         strike_cnt <= '0;
         progress   <= '0;
         arm_err    <= 1'b0;
         prev       <= '1;
         wire_q     <= '1;
         order_q    <= '0;
         len_q      <= (IDX_W+1)'(1);
      end else begin
         strike  <= 1'b0;
         arm_err <= 1'b0;
         wire_q  <= wire_lvl;
         case (state)
            ST_ACTIVE: begin
               prev <= wire_q;
               if (game_over) begin
                  state <= ST_EXPLODED;
               end else if (strike_now) begin
                  strike <= 1'b1;
                  if (strike_cnt != CNT_W'(MAX_STRIKES))
                     strike_cnt <= strike_cnt + CNT_W'(1);
                  if (strike_cnt >= CNT_W'(MAX_STRIKES - 1))
                     state <= ST_EXPLODED;
               end else begin
                  if (correct_cut || skip)
                     progress <= progress + (IDX_W+1)'(1);
                  if (complete)
                     state <= ST_DEFUSED;
               end
            end
            default: begin
               if (start) begin
                  if (&wire_lvl) begin
                     state      <= ST_ACTIVE;
                     order_q    <= cut_order;
                     len_q      <= len_clamped;
                     strike_cnt <= '0;
                     progress   <= '0;
                     prev       <= wire_lvl;
                  end else begin
                     arm_err <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wire_cut_judge.sv
// ---------------------------------------------------------------------------
// tb_wire_cut_judge
//
// Directed bench for wire_cut_judge. Most of the game is played from a
// table, one row per clock. Each row gives the inputs for that clock and
// the registered outputs expected after it. A few hand-written sequences
// then cover the double cut, a reset in the middle of a game and, when the
// option is built in, the reconnect strike.
// ---------------------------------------------------------------------------
module tb_wire_cut_judge;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ACTIVE   = 2'd1;
   localparam logic [1:0] DEFUSED  = 2'd2;
   localparam logic [1:0] EXPLODED = 2'd3;

   localparam logic [5:0]  ALL = 6'h3F;
   localparam logic [17:0] ORD = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
   localparam logic [17:0] BAD = 18'h3FFFF;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  wire_lvl;
   logic [17:0] cut_order;
   logic [3:0]  cut_len;
   logic        game_over;
   logic [1:0]  state;
   logic        strike;
   logic [1:0]  strike_cnt;
   logic [3:0]  progress;
   logic        arm_err;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic        r;
      logic        s;
      logic [5:0]  wl;
      logic [17:0] ord;
      logic [3:0]  len;
      logic        go;
      logic [1:0]  eState;
      logic        eStrike;
      logic [1:0]  eCnt;
      logic [3:0]  eProg;
      logic        eArmErr;
   } vec_t;

   vec_t vecs[$];

   wire_cut_judge #(.NUM_WIRES(6), .MAX_STRIKES(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .wire_lvl   (wire_lvl),
      .cut_order  (cut_order),
      .cut_len    (cut_len),
      .game_over  (game_over),
      .state      (state),
      .strike     (strike),
      .strike_cnt (strike_cnt),
      .progress   (progress),
      .arm_err    (arm_err)
   );

   // Free-running clock with a 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one clock's worth of inputs, then wait until just after the edge
   // so that the registered outputs can be sampled.
   task automatic applyStimulus(input logic r, input logic s, input logic [5:0] wl,
                                input logic [17:0] ord, input logic [3:0] len,
                                input logic go);
      rst       = r;
      start     = s;
      wire_lvl  = wl;
      cut_order = ord;
      cut_len   = len;
      game_over = go;
      @(posedge clk);
      #1;
   endtask

   // Compare every output against the expected value. One call counts as
   // one test.
   task automatic checkOutput(input string name, input logic [1:0] eState,
                              input logic eStrike, input logic [1:0] eCnt,
                              input logic [3:0] eProg, input logic eArmErr);
      testsRun++;
      if (state !== eState || strike !== eStrike || strike_cnt !== eCnt ||
          progress !== eProg || arm_err !== eArmErr) begin
         testsFailed++;
         $display("[TB] FAIL %s: got state=%0d strike=%0b cnt=%0d prog=%0d arm_err=%0b, want state=%0d strike=%0b cnt=%0d prog=%0d arm_err=%0b",
                  name, state, strike, strike_cnt, progress, arm_err,
                  eState, eStrike, eCnt, eProg, eArmErr);
      end
   endtask

   task automatic addVec(input logic r, input logic s, input logic [5:0] wl,
                         input logic [17:0] ord, input logic [3:0] len, input logic go,
                         input logic [1:0] st, input logic sk, input logic [1:0] cnt,
                         input logic [3:0] prog, input logic ae);
      vec_t v;
      v.r = r; v.s = s; v.wl = wl; v.ord = ord; v.len = len; v.go = go;
      v.eState = st; v.eStrike = sk; v.eCnt = cnt; v.eProg = prog; v.eArmErr = ae;
      vecs.push_back(v);
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      wire_lvl  = ALL;
      cut_order = ORD;
      cut_len   = 4'd3;
      game_over = 1'b0;

      // Reset, then an arm attempt with wire 0 cut, then an arm with all wires intact.
      addVec(0,0,ALL,  ORD,3,0, IDLE,    0,0,0,0);
      addVec(1,0,ALL,  ORD,3,0, IDLE,    0,0,0,0);
      addVec(1,1,6'h3E,ORD,3,0, IDLE,    0,0,0,1);
      addVec(1,0,ALL,  ORD,3,0, IDLE,    0,0,0,0);
      addVec(1,1,ALL,  ORD,3,0, ACTIVE,  0,0,0,0);
      // Cut 0, 1, 2 in order. Each cut is judged one clock after it is sampled.
      addVec(1,0,6'h3E,ORD,3,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h3E,ORD,3,0, ACTIVE,  0,0,1,0);
      addVec(1,0,6'h3C,ORD,3,0, ACTIVE,  0,0,1,0);
      addVec(1,0,6'h3C,ORD,3,0, ACTIVE,  0,0,2,0);
      addVec(1,0,6'h38,ORD,3,0, ACTIVE,  0,0,2,0);
      addVec(1,0,6'h38,ORD,3,0, ACTIVE,  0,0,3,0);
      addVec(1,0,6'h38,ORD,3,0, DEFUSED, 0,0,3,0);
      // Cutting a wire while DEFUSED is ignored.
      addVec(1,0,6'h30,ORD,3,0, DEFUSED, 0,0,3,0);
      addVec(1,0,6'h30,ORD,3,0, DEFUSED, 0,0,3,0);
      // Re-arm. Cutting wire 4 first is a strike. Cutting wire 0 after it is correct.
      addVec(1,1,ALL,  ORD,3,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h2F,ORD,3,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h2F,ORD,3,0, ACTIVE,  1,1,0,0);
      addVec(1,0,6'h2E,ORD,3,0, ACTIVE,  0,1,0,0);
      addVec(1,0,6'h2E,ORD,3,0, ACTIVE,  0,1,1,0);
      // start while ACTIVE is ignored. game_over explodes the puzzle without a strike.
      addVec(1,1,6'h2E,ORD,3,0, ACTIVE,  0,1,1,0);
      addVec(1,0,6'h2E,ORD,3,1, EXPLODED,0,1,1,0);
      addVec(1,0,6'h2E,ORD,3,0, EXPLODED,0,1,1,0);
      // Three wrong cuts (4, 5, 3): the third strike explodes the puzzle.
      addVec(1,1,ALL,  ORD,3,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h2F,ORD,3,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h2F,ORD,3,0, ACTIVE,  1,1,0,0);
      addVec(1,0,6'h0F,ORD,3,0, ACTIVE,  0,1,0,0);
      addVec(1,0,6'h0F,ORD,3,0, ACTIVE,  1,2,0,0);
      addVec(1,0,6'h07,ORD,3,0, ACTIVE,  0,2,0,0);
      addVec(1,0,6'h07,ORD,3,0, EXPLODED,1,3,0,0);
      addVec(1,0,6'h07,ORD,3,0, EXPLODED,0,3,0,0);
      // A length of 0 is raised to 1, so a single correct cut defuses.
      addVec(1,1,ALL,  ORD,0,0, ACTIVE,  0,0,0,0);
      addVec(1,0,ALL,  ORD,0,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h3E,ORD,0,0, ACTIVE,  0,0,0,0);
      addVec(1,0,6'h3E,ORD,0,0, ACTIVE,  0,0,1,0);
      addVec(1,0,6'h3E,ORD,0,0, DEFUSED, 0,0,1,0);
      // Every entry is invalid and the length of 7 is cut down to 6: one skip per clock.
      addVec(1,1,ALL,  BAD,7,0, ACTIVE,  0,0,0,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,1,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,2,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,3,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,4,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,5,0);
      addVec(1,0,ALL,  BAD,7,0, ACTIVE,  0,0,6,0);
      addVec(1,0,ALL,  BAD,7,0, DEFUSED, 0,0,6,0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].r, vecs[i].s, vecs[i].wl, vecs[i].ord, vecs[i].len, vecs[i].go);
         checkOutput($sformatf("vec%0d", i), vecs[i].eState, vecs[i].eStrike,
                     vecs[i].eCnt, vecs[i].eProg, vecs[i].eArmErr);
      end

      // Wires 0 and 1 cut in the same clock give exactly one strike. After
      // that, entries 0 and 1 are skipped, one per clock.
      applyStimulus(1,1,ALL,  ORD,3,0); checkOutput("dbl_arm",   ACTIVE,0,0,0,0);
      applyStimulus(1,0,6'h3C,ORD,3,0); checkOutput("dbl_samp",  ACTIVE,0,0,0,0);
      applyStimulus(1,0,6'h3C,ORD,3,0); checkOutput("dbl_strike",ACTIVE,1,1,0,0);
      applyStimulus(1,0,6'h3C,ORD,3,0); checkOutput("dbl_skip0", ACTIVE,0,1,1,0);
      applyStimulus(1,0,6'h3C,ORD,3,0); checkOutput("dbl_skip1", ACTIVE,0,1,2,0);
      applyStimulus(1,0,6'h3C,ORD,3,0); checkOutput("dbl_wait",  ACTIVE,0,1,2,0);

      // A reset in the middle of a game clears everything on the next edge.
      applyStimulus(0,0,6'h3C,ORD,3,0); checkOutput("mid_reset", IDLE,0,0,0,0);

`ifdef WIRE_RECONNECT_STRIKE_EN
      // Reconnecting wire 4 after it was cut is a second strike.
      applyStimulus(1,1,ALL,  ORD,3,0); checkOutput("rc_arm",    ACTIVE,0,0,0,0);
      applyStimulus(1,0,6'h2F,ORD,3,0); checkOutput("rc_samp",   ACTIVE,0,0,0,0);
      applyStimulus(1,0,6'h2F,ORD,3,0); checkOutput("rc_cut",    ACTIVE,1,1,0,0);
      applyStimulus(1,0,ALL,  ORD,3,0); checkOutput("rc_samp2",  ACTIVE,0,1,0,0);
      applyStimulus(1,0,ALL,  ORD,3,0); checkOutput("rc_strike", ACTIVE,1,2,0,0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
